// File: rtl/regfile_write_ctrl.sv
// Write-port controller for the register file: zero sweep after reset or clr_req, then round-robin
// arbitration of two requesters. Write lands on the port one cycle after the handshake; readies drop during the sweep.
module regfile_write_ctrl #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rf_regWrite,
  output logic [ADDR_W-1:0] rf_writeReg,
  output logic [DATA_W-1:0] rf_writeData,
  output logic              init_busy
);

  typedef enum logic {INIT, RUN} stateT;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  stateT             state;
  logic [ADDR_W-1:0] cnt;
  logic              last;
  logic              grant0;
  logic              grant1;

  // The requester that did not win most recently gets priority under contention.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == RUN && !clr_req) begin
      grant0 = req0_valid && (!req1_valid || last);
      grant1 = req1_valid && (!req0_valid || !last);
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign init_busy  = (state == INIT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= INIT;
      cnt          <= '0;
      last         <= 1'b1;
      rf_regWrite  <= 1'b0;
      rf_writeReg  <= '0;
      rf_writeData <= '0;
    end else begin
      case (state)
        INIT: begin
          rf_regWrite  <= 1'b1;
          rf_writeReg  <= cnt;
          rf_writeData <= '0;
          if (cnt == LAST_ADDR) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        RUN: begin
          if (clr_req) begin
            state       <= INIT;
            cnt         <= '0;
            rf_regWrite <= 1'b0;
          end else if (grant0) begin
            rf_regWrite  <= 1'b1;
            rf_writeReg  <= req0_addr;
            rf_writeData <= req0_data;
            last         <= 1'b0;
          end else if (grant1) begin
            rf_regWrite  <= 1'b1;
            rf_writeReg  <= req1_addr;
            rf_writeData <= req1_data;
            last         <= 1'b1;
          end else begin
            rf_regWrite <= 1'b0;
          end
        end
        default: begin
          state       <= INIT;
          cnt         <= '0;
          rf_regWrite <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Randomised bench for regfile_write_ctrl with a register-file model behind the write port.
module tb_regfile_write_ctrl;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clr_req = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic [DW-1:0] req0_data = '0, req1_data = '0;
  logic          req0_ready, req1_ready, rf_regWrite, init_busy;
  logic [AW-1:0] rf_writeReg;
  logic [DW-1:0] rf_writeData;

  regfile_write_ctrl #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .clr_req(clr_req),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .rf_regWrite(rf_regWrite), .rf_writeReg(rf_writeReg), .rf_writeData(rf_writeData),
    .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  int            vectors = 0;
  int            errors = 0;
  int            mLast = 1;
  logic [DW-1:0] expMem [NR];
  logic [DW-1:0] rfMem [NR];
  logic [AW-1:0] expAddr = '0;
  logic [DW-1:0] expData = '0;

  // Register file sitting behind the write port.
  always @(posedge clk) if (rf_regWrite === 1'b1) rfMem[rf_writeReg] <= rf_writeData;

  // Expected winner: -1 none, else requester index; the one not served last wins a tie.
  function automatic int model_grant(logic v0, logic v1, logic clr);
    if (clr) return -1;
    if (v0 && v1) return (mLast == 0) ? 1 : 0;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic test_reset();
    reset = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      vectors++;
      if ({rf_regWrite, rf_writeReg, rf_writeData, init_busy, req0_ready, req1_ready} !==
          {1'b0, AW'(0), DW'(0), 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_state: we=%b addr=%0d data=%h busy=%b rdy=%b%b, want 0 0 0 1 00",
                 rf_regWrite, rf_writeReg, rf_writeData, init_busy, req0_ready, req1_ready);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    mLast = 1;
  endtask

  task automatic test_sweep();
    for (int i = 0; i < NR; i++) begin
      #1;
      vectors++;
      if ({init_busy, req0_ready, req1_ready} !== 3'b100) begin
        errors++;
        $display("FAIL sweep_busy[%0d]: busy=%b rdy=%b%b, want busy=1 rdy=00",
                 i, init_busy, req0_ready, req1_ready);
      end
      @(posedge clk); #1;
      vectors++;
      if ({rf_regWrite, rf_writeReg, rf_writeData} !== {1'b1, AW'(i), DW'(0)}) begin
        errors++;
        $display("FAIL sweep_write[%0d]: we=%b addr=%0d data=%h, want 1 %0d 0",
                 i, rf_regWrite, rf_writeReg, rf_writeData, i);
      end
      @(negedge clk);
    end
    foreach (expMem[k]) expMem[k] = '0;
    expAddr = AW'(NR - 1);
    expData = '0;
    vectors++;
    if (init_busy !== 1'b0) begin
      errors++;
      $display("FAIL sweep_end: init_busy=%b, want 0", init_busy);
    end
  endtask

  task automatic test_single();
    int g;
    req0_valid = 1'b1; req0_addr = 5; req0_data = 32'hDEADBEEF; req1_valid = 1'b0;
    g = model_grant(1'b1, 1'b0, 1'b0);
    #1;
    vectors++;
    if ({req0_ready, req1_ready} !== {g == 0, g == 1}) begin
      errors++;
      $display("FAIL single_ready: rdy=%b%b, want %b%b", req0_ready, req1_ready, g == 0, g == 1);
    end
    @(posedge clk); #1;
    mLast = g; expMem[5] = 32'hDEADBEEF; expAddr = 5; expData = 32'hDEADBEEF;
    vectors++;
    if ({rf_regWrite, rf_writeReg, rf_writeData} !== {1'b1, expAddr, expData}) begin
      errors++;
      $display("FAIL single_write: we=%b addr=%0d data=%h, want 1 5 deadbeef",
               rf_regWrite, rf_writeReg, rf_writeData);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({rf_regWrite, rf_writeReg, rf_writeData} !== {1'b0, expAddr, expData}) begin
      errors++;
      $display("FAIL single_idle: we=%b addr=%0d data=%h, want 0 5 deadbeef",
               rf_regWrite, rf_writeReg, rf_writeData);
    end
    vectors++;
    if (rfMem[5] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_readback: reg5=%h, want deadbeef", rfMem[5]);
    end
    @(negedge clk);
  endtask

  task automatic test_contention();
    int g;
    req0_valid = 1'b1; req0_addr = 1; req0_data = 32'h11;
    req1_valid = 1'b1; req1_addr = 2; req1_data = 32'h22;
    for (int c = 0; c < 6; c++) begin
      g = model_grant(1'b1, 1'b1, 1'b0);
      #1;
      vectors++;
      if ({req0_ready, req1_ready} !== {g == 0, g == 1}) begin
        errors++;
        $display("FAIL contention_ready[%0d]: rdy=%b%b, want %b%b",
                 c, req0_ready, req1_ready, g == 0, g == 1);
      end
      @(posedge clk); #1;
      mLast = g;
      expAddr = (g == 0) ? AW'(1) : AW'(2);
      expData = (g == 0) ? 32'h11 : 32'h22;
      expMem[expAddr] = expData;
      vectors++;
      if ({rf_regWrite, rf_writeReg, rf_writeData} !== {1'b1, expAddr, expData}) begin
        errors++;
        $display("FAIL contention_write[%0d]: we=%b addr=%0d data=%h, want 1 %0d %h",
                 c, rf_regWrite, rf_writeReg, rf_writeData, expAddr, expData);
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_same_addr();
    int g;
    // Bring the arbiter to "requester 1 served last" so requester 0 wins the tie.
    if (mLast != 1) begin
      req1_valid = 1'b1; req1_addr = 7; req1_data = 32'h0;
      @(posedge clk);
      mLast = 1; expMem[7] = 32'h0; expAddr = 7; expData = 32'h0;
      @(negedge clk);
    end
    req0_valid = 1'b1; req0_addr = 7; req0_data = 32'hA;
    req1_valid = 1'b1; req1_addr = 7; req1_data = 32'hB;
    for (int c = 0; c < 2; c++) begin
      g = model_grant(req0_valid, req1_valid, 1'b0);
      #1;
      vectors++;
      if ({req0_ready, req1_ready} !== {g == 0, g == 1}) begin
        errors++;
        $display("FAIL same_addr_ready[%0d]: rdy=%b%b, want %b%b",
                 c, req0_ready, req1_ready, g == 0, g == 1);
      end
      @(posedge clk); #1;
      mLast = g; expAddr = 7; expData = (g == 0) ? 32'hA : 32'hB; expMem[7] = expData;
      vectors++;
      if ({rf_regWrite, rf_writeReg, rf_writeData} !== {1'b1, expAddr, expData}) begin
        errors++;
        $display("FAIL same_addr_write[%0d]: we=%b addr=%0d data=%h, want 1 7 %h",
                 c, rf_regWrite, rf_writeReg, rf_writeData, expData);
      end
      @(negedge clk);
      if (g == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    end
    @(posedge clk); #1;
    vectors++;
    if (rfMem[7] !== 32'hB) begin
      errors++;
      $display("FAIL same_addr_final: reg7=%h, want b", rfMem[7]);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int   g;
    logic pend0 = 1'b0, pend1 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (pend0 && $urandom_range(0, 9) == 0) pend0 = 1'b0;
      else if (!pend0 && $urandom_range(0, 9) < 6) begin
        pend0 = 1'b1; req0_addr = AW'($urandom_range(0, NR - 1)); req0_data = $urandom;
      end
      if (pend1 && $urandom_range(0, 9) == 0) pend1 = 1'b0;
      else if (!pend1 && $urandom_range(0, 9) < 6) begin
        pend1 = 1'b1; req1_addr = AW'($urandom_range(0, NR - 1)); req1_data = $urandom;
      end
      req0_valid = pend0; req1_valid = pend1;
      g = model_grant(pend0, pend1, 1'b0);
      #1;
      vectors++;
      if ({req0_ready, req1_ready} !== {g == 0, g == 1}) begin
        errors++;
        $display("FAIL random_ready[%0d]: rdy=%b%b, want %b%b",
                 c, req0_ready, req1_ready, g == 0, g == 1);
      end
      @(posedge clk); #1;
      if (g == 0) begin
        expAddr = req0_addr; expData = req0_data; pend0 = 1'b0;
      end else if (g == 1) begin
        expAddr = req1_addr; expData = req1_data; pend1 = 1'b0;
      end
      if (g >= 0) begin
        mLast = g;
        expMem[expAddr] = expData;
      end
      vectors++;
      if ({rf_regWrite, rf_writeReg, rf_writeData} !== {g >= 0, expAddr, expData}) begin
        errors++;
        $display("FAIL random_write[%0d]: we=%b addr=%0d data=%h, want %b %0d %h",
                 c, rf_regWrite, rf_writeReg, rf_writeData, g >= 0, expAddr, expData);
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_readback();
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    for (int r = 0; r < NR; r++) begin
      vectors++;
      if (rfMem[r] !== expMem[r]) begin
        errors++;
        $display("FAIL readback[%0d]: got %h, want %h", r, rfMem[r], expMem[r]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_clr();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_addr = 9; req1_data = 32'h99;
    clr_req = 1'b1;
    #1;
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      errors++;
      $display("FAIL clr_ready: rdy=%b%b, want 00", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if ({rf_regWrite, init_busy} !== 2'b01) begin
      errors++;
      $display("FAIL clr_edge: we=%b busy=%b, want we=0 busy=1", rf_regWrite, init_busy);
    end
    @(negedge clk);
    clr_req = 1'b0;
  endtask

  task automatic test_clr_served();
    int g;
    g = model_grant(req0_valid, req1_valid, 1'b0);
    #1;
    vectors++;
    if ({req0_ready, req1_ready} !== {g == 0, g == 1}) begin
      errors++;
      $display("FAIL clr_served_ready: rdy=%b%b, want %b%b", req0_ready, req1_ready, g == 0, g == 1);
    end
    @(posedge clk); #1;
    mLast = g; expAddr = 9; expData = 32'h99; expMem[9] = 32'h99;
    vectors++;
    if ({rf_regWrite, rf_writeReg, rf_writeData} !== {1'b1, expAddr, expData}) begin
      errors++;
      $display("FAIL clr_served_write: we=%b addr=%0d data=%h, want 1 9 99",
               rf_regWrite, rf_writeReg, rf_writeData);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1; mLast = 1;
    for (int i = 0; i <= 10; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
    end
    vectors++;
    if ({rf_regWrite, rf_writeReg} !== {1'b1, AW'(10)}) begin
      errors++;
      $display("FAIL reset_mid_pos: we=%b addr=%0d, want 1 10", rf_regWrite, rf_writeReg);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({rf_regWrite, rf_writeReg, rf_writeData, init_busy} !== {1'b0, AW'(0), DW'(0), 1'b1}) begin
      errors++;
      $display("FAIL reset_mid_cancel: we=%b addr=%0d data=%h busy=%b, want 0 0 0 1",
               rf_regWrite, rf_writeReg, rf_writeData, init_busy);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_single();
    test_contention();
    test_same_addr();
    test_random();
    test_readback();
    test_clr();
    test_sweep();
    test_clr_served();
    test_readback();
    test_reset_mid();
    test_sweep();
    test_readback();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/regfile_write_ctrl.md
# regfile_write_ctrl

Write-port controller for the 32 x 32-bit register file. After reset, or on request, it sweeps every register to zero. It then shares the single write port between two requesters using round-robin arbitration and valid/ready handshakes. It sits directly in front of the register file's `regWrite` / `writeReg` / `writeData` inputs and is the only block that drives them.

## Interface
- `NUM_REGS`, 32, number of registers swept during clear; must be ≤ 2^`ADDR_W`.
- `ADDR_W`, 5, register address width.
- `DATA_W`, 32, register data width.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `clr_req`  in  1  one-cycle request to re-run the zero sweep; honoured only in RUN.
- `req0_valid`  in  1  requester 0 has a write pending.
- `req0_addr`  in  `ADDR_W`  requester 0 target register.
- `req0_data`  in  `DATA_W`  requester 0 write data.
- `req0_ready`  out  1  requester 0 write accepted this cycle.
- `req1_valid`, `req1_addr`, `req1_data`, `req1_ready`  same as requester 0, for requester 1.
- `rf_regWrite`  out  1  registered write enable to the register file.
- `rf_writeReg`  out  `ADDR_W`  registered write address.
- `rf_writeData`  out  `DATA_W`  registered write data.
- `init_busy`  out  1  high while the zero sweep is in progress.

## Operation
- States:
  - INIT: zero sweep; counter `cnt` runs 0..`NUM_REGS`-1.
  - RUN: arbitration.
- Reset (`reset`=0 at an edge):
  - state=INIT, `cnt`=0, `last`=1 (requester 0 preferred first).
  - `rf_regWrite`=0, `rf_writeReg`=0, `rf_writeData`=0.
  - `init_busy`=1 (state decode); `req0_ready`=`req1_ready`=0.
- INIT behaviour:
  - Each edge registers `rf_regWrite`=1, `rf_writeReg`=`cnt`, `rf_writeData`=0, then increments `cnt`.
  - At the edge where `cnt`=`NUM_REGS`-1: go to RUN and clear `cnt` to 0.
  - Both readies held 0. `clr_req` is ignored.
- RUN arbitration, combinational readies:
  - Only `req0_valid`: `req0_ready`=1.
  - Only `req1_valid`: `req1_ready`=1.
  - Both valid: grant the requester ≠ `last`.
  - At most one ready is high per cycle. Ready is never high without its valid.
- RUN, on a handshake (valid & ready) at an edge:
  - Register `rf_regWrite`=1 and the granted addr/data.
  - Set `last` to the granted index.
- RUN, no handshake: register `rf_regWrite`=0. Address and data hold their previous values.
- `clr_req`=1 in RUN:
  - Both readies forced 0 that cycle, so no grant.
  - Next state INIT with `cnt`=0; `rf_regWrite`=0 at that edge.
- No address filtering or collision logic: same-address requests are serialised by arbitration. Register 0 is writable.

## Timing
- Write latency: handshake at edge N drives the port during cycle N..N+1. The register file stores the value at edge N+1.
- Sweep:
  - The first edge with `reset`=1 (E0) presents address 0.
  - Edge E(`NUM_REGS`-1) presents the last address and enters RUN.
  - `init_busy` falls after E(`NUM_REGS`-1).
  - The earliest handshake is at E(`NUM_REGS`), so it never overlaps the sweep.
- Sustained throughput: one write per cycle. Under continuous contention, grants alternate 0,1,0,1.
- A requester must hold valid/addr/data stable until ready. Dropping valid before ready is allowed; no write is issued.
- Reset mid-sweep or mid-RUN:
  - Outputs go to reset values at that edge.
  - Any in-flight registered write is cancelled (`rf_regWrite`=0).
  - The sweep restarts from 0.
- `clr_req` coincident with valids: `clr_req` wins; requesters stay pending and are served after the new sweep.

## Test plan
- Reset release: hold `reset`=0 for 3 cycles, then 1. Expect:
  - `rf_regWrite`=1 with addresses 0..31 in consecutive cycles, data 0.
  - `init_busy` high for exactly 32 cycles.
  - No readies asserted during the sweep.
- Single requester: after the sweep, `req0_valid`=1, addr=5, data=0xDEADBEEF. Expect:
  - `req0_ready`=1 the same cycle.
  - Next cycle `rf_regWrite`=1, `rf_writeReg`=5, `rf_writeData`=0xDEADBEEF.
  - Readback of reg 5 gives 0xDEADBEEF.
- Contention: both requesters valid continuously, req0 addr 1 / data 0x11, req1 addr 2 / data 0x22. Expect:
  - Grant order req0, req1, req0, req1.
  - One write per cycle; never both readies high.
- Same address: both valid, addr 7, data 0xA and 0xB, with `last`=1. Expect:
  - Writes 0xA then 0xB.
  - Final reg 7 = 0xB.
- `clr_req` with pending valids: registers previously written non-zero; pulse `clr_req` while req1 is valid. Expect:
  - No grant that cycle.
  - Full 32-cycle zero sweep.
  - Then req1 served; all other registers read 0.
- Reset mid-sweep: drop `reset` at sweep address 10. Expect:
  - `rf_regWrite`=0 next cycle.
  - After release, the sweep restarts at address 0 and completes all 32.
